// File: rtl/lix_shr_sink_pkg.sv
// Shared constants and helpers for the lix_shr_sink enable-stalled pipeline sink.
//
// Contents:
//   D_MIN / D_MAX : legal range of the buffer depth parameter D
//   occ_w(d)      : width of an occupancy counter that must hold 0..d inclusive
package lix_shr_sink_pkg;

  localparam int D_MIN = 2;
  localparam int D_MAX = 64;

  // A counter spanning 0..d needs one bit more than the pointer width,
  // because d itself (full) must be representable.
  function automatic int occ_w(input int d);
    return $clog2(d) + 1;
  endfunction

endpackage

// File: rtl/lix_shr_sink_mem.sv
// Storage for lix_shr_sink: D x W register array with one synchronous write
// port and one asynchronous (combinational) read port.
//
// Ports:
//   clk_i   : clock, writes on rising edge
//   we_i    : write enable
//   waddr_i : write address
//   wdata_i : write data
//   raddr_i : read address
//   rdata_o : read data, combinational from raddr_i
//
// The array is deliberately not reset; the owner masks the read data
// whenever the addressed entry is not valid.
module lix_sink_mem #(
  parameter int W = 32,
  parameter int D = 4
) (
  input  logic                 clk_i,
  input  logic                 we_i,
  input  logic [$clog2(D)-1:0] waddr_i,
  input  logic [W-1:0]         wdata_i,
  input  logic [$clog2(D)-1:0] raddr_i,
  output logic [W-1:0]         rdata_o
);

  logic [W-1:0] mem_q [D];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/lix_shr_sink.sv
// lix_shr_sink: terminates an enable-stalled upstream pipeline and re-times
// it onto a valid/ready downstream interface through a small FIFO.
//
// Ports:
//   clk_i   : clock, all state on rising edge
//   rst_i   : asynchronous active-high reset
//   i_vld   : valid from the last upstream stage
//   i_x     : data from the last upstream stage
//   o_en    : advance enable broadcast to every upstream stage
//   i_flush : synchronous buffer clear
//   o_vld   : downstream valid
//   i_rdy   : downstream ready
//   o_z     : downstream data (zero when o_vld=0)
//   o_cnt   : current occupancy, 0..D
//
// Handshakes:
//   upstream   - a push happens on an edge where o_en=1 and i_vld=1; with
//                o_en=1 and i_vld=0 the bubble is consumed without a write;
//                with o_en=0 the upstream holds and i_vld/i_x are ignored.
//   downstream - a pop happens on an edge where o_vld=1 and i_rdy=1; o_vld
//                and o_z stay stable while waiting for i_rdy.
//   o_en never depends on i_vld or i_rdy, so a full buffer that pops this
//   cycle only re-enables the upstream on the following cycle.
module lix_shr_sink
  import lix_shr_sink_pkg::*;
#(
  parameter int W = 32,
  parameter int D = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 i_vld,
  input  logic [W-1:0]         i_x,
  output logic                 o_en,
  input  logic                 i_flush,
  output logic                 o_vld,
  input  logic                 i_rdy,
  output logic [W-1:0]         o_z,
  output logic [occ_w(D)-1:0]  o_cnt
);

  localparam int AW = $clog2(D);
  localparam int CW = occ_w(D);

  if (D < D_MIN || D > D_MAX || (D & (D - 1)) != 0) begin : g_bad_depth
    $error("lix_shr_sink: D must be a power of two in [D_MIN, D_MAX]");
  end

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          push;
  logic          pop;
  logic [W-1:0]  rd_data;

  // Enable decodes registered occupancy only; flush also freezes upstream
  // so nothing is accepted on the clearing edge.
  assign o_en  = (cnt_q != CW'(D)) & ~i_flush;
  assign o_vld = (cnt_q != '0);
  assign push  = o_en & i_vld;
  assign pop   = o_vld & i_rdy;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (i_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      // D is a power of two, so pointer wrap is the natural AW-bit rollover.
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  lix_sink_mem #(
    .W (W),
    .D (D)
  ) u_mem (
    .clk_i   (clk_i),
    .we_i    (push),
    .waddr_i (wr_ptr_q),
    .wdata_i (i_x),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_data)
  );

  // Storage is unreset, so the read data is masked while empty.
  assign o_z   = o_vld ? rd_data : '0;
  assign o_cnt = cnt_q;

endmodule

// File: tb/tb_lix_shr_sink.sv
module tb_lix_shr_sink;

  localparam int W  = 32;
  localparam int D  = 4;
  localparam int CW = $clog2(D) + 1;
  localparam int NV = 28;

  logic          clk;
  logic          rst;
  logic          vld;
  logic [W-1:0]  x;
  logic          en;
  logic          flush;
  logic          ovld;
  logic          rdy;
  logic [W-1:0]  z;
  logic [CW-1:0] cnt;

  int tests;
  int fails;

  logic [W-1:0] exp_q[$];

  typedef struct {
    logic         flush;
    logic         vld;
    logic [W-1:0] x;
    logic         rdy;
    logic         en;
    logic         ovld;
    logic [W-1:0] z;
    int           cnt;
  } vec_t;

  vec_t tbl[NV];

  lix_shr_sink #(.W(W), .D(D)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .i_vld   (vld),
    .i_x     (x),
    .o_en    (en),
    .i_flush (flush),
    .o_vld   (ovld),
    .i_rdy   (rdy),
    .o_z     (z),
    .o_cnt   (cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // checking
  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic e_en, input logic e_vld,
                           input logic [W-1:0] e_z, input int e_cnt);
    check({tag, ".o_en"},  W'(en),   W'(e_en));
    check({tag, ".o_vld"}, W'(ovld), W'(e_vld));
    check({tag, ".o_z"},   z,        e_z);
    check({tag, ".o_cnt"}, W'(cnt),  W'(e_cnt));
  endtask

  function automatic vec_t mk(input logic f, input logic v, input logic [W-1:0] xi,
                              input logic r, input logic e, input logic ov,
                              input logic [W-1:0] ez, input int ec);
    vec_t t;
    t.flush = f; t.vld = v; t.x = xi; t.rdy = r;
    t.en = e; t.ovld = ov; t.z = ez; t.cnt = ec;
    return t;
  endfunction

  // driver: inputs change 1 time unit after the rising edge
  task automatic drive(input logic f, input logic v, input logic [W-1:0] xi, input logic r);
    @(posedge clk);
    #1;
    flush = f; vld = v; x = xi; rdy = r;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1; vld = 1'b0; x = '0; flush = 1'b0; rdy = 1'b0;

    // Outputs observed on the falling edge reflect state before the next
    // rising edge, with the current inputs applied.
    //                 fl  vld x       rdy   en  ovld z       cnt
    tbl[0]  = mk(1'b0, 1'b1, 32'h1,  1'b0, 1'b1, 1'b0, 32'h0,  0); // fill 1..4
    tbl[1]  = mk(1'b0, 1'b1, 32'h2,  1'b0, 1'b1, 1'b1, 32'h1,  1);
    tbl[2]  = mk(1'b0, 1'b1, 32'h3,  1'b0, 1'b1, 1'b1, 32'h1,  2);
    tbl[3]  = mk(1'b0, 1'b1, 32'h4,  1'b0, 1'b1, 1'b1, 32'h1,  3);
    tbl[4]  = mk(1'b0, 1'b1, 32'h5,  1'b0, 1'b0, 1'b1, 32'h1,  4); // full, 5 held
    tbl[5]  = mk(1'b0, 1'b1, 32'h5,  1'b0, 1'b0, 1'b1, 32'h1,  4);
    tbl[6]  = mk(1'b0, 1'b1, 32'h5,  1'b1, 1'b0, 1'b1, 32'h1,  4); // pop 1, en stays 0
    tbl[7]  = mk(1'b0, 1'b1, 32'h5,  1'b0, 1'b1, 1'b1, 32'h2,  3); // en back, push 5 (wrap)
    tbl[8]  = mk(1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 32'h2,  4); // drain 2,3,4,5
    tbl[9]  = mk(1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 1'b1, 32'h3,  3);
    tbl[10] = mk(1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 1'b1, 32'h4,  2);
    tbl[11] = mk(1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 1'b1, 32'h5,  1);
    tbl[12] = mk(1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 32'h0,  0);
    tbl[13] = mk(1'b0, 1'b1, 32'hA,  1'b1, 1'b1, 1'b0, 32'h0,  0); // bubbles 1,0,1,0
    tbl[14] = mk(1'b0, 1'b0, 32'hEE, 1'b1, 1'b1, 1'b1, 32'hA,  1);
    tbl[15] = mk(1'b0, 1'b1, 32'hB,  1'b1, 1'b1, 1'b0, 32'h0,  0);
    tbl[16] = mk(1'b0, 1'b0, 32'hEE, 1'b1, 1'b1, 1'b1, 32'hB,  1);
    tbl[17] = mk(1'b0, 1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 32'h0,  0);
    tbl[18] = mk(1'b0, 1'b1, 32'h11, 1'b0, 1'b1, 1'b0, 32'h0,  0); // build 3 entries
    tbl[19] = mk(1'b0, 1'b1, 32'h22, 1'b0, 1'b1, 1'b1, 32'h11, 1);
    tbl[20] = mk(1'b0, 1'b1, 32'h33, 1'b0, 1'b1, 1'b1, 32'h11, 2);
    tbl[21] = mk(1'b1, 1'b1, 32'h44, 1'b1, 1'b0, 1'b1, 32'h11, 3); // flush wins
    tbl[22] = mk(1'b0, 1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 32'h0,  0);
    tbl[23] = mk(1'b0, 1'b1, 32'h55, 1'b0, 1'b1, 1'b0, 32'h0,  0);
    tbl[24] = mk(1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 1'b1, 32'h55, 1);
    tbl[25] = mk(1'b0, 1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 32'h0,  0);
    tbl[26] = mk(1'b1, 1'b1, 32'h66, 1'b0, 1'b0, 1'b0, 32'h0,  0); // flush blocks push
    tbl[27] = mk(1'b0, 1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 32'h0,  0);

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all("reset", 1'b1, 1'b0, 32'h0, 0);
    rst = 1'b0;

    // table-driven vectors
    for (int i = 0; i < NV; i++) begin
      drive(tbl[i].flush, tbl[i].vld, tbl[i].x, tbl[i].rdy);
      @(negedge clk);
      check_all($sformatf("vec%0d", i), tbl[i].en, tbl[i].ovld, tbl[i].z, tbl[i].cnt);
    end

    // streaming 0..19 with i_rdy=1: occupancy 0/1, strict order through 5 wraps
    exp_q.delete();
    for (int k = 0; k <= 20; k++) begin
      if (k < 20) begin
        drive(1'b0, 1'b1, W'(k), 1'b1);
        exp_q.push_back(W'(k));
      end else begin
        drive(1'b0, 1'b0, '0, 1'b1);
      end
      @(negedge clk);
      check($sformatf("stream%0d.o_cnt", k), W'(cnt), (k == 0) ? 32'd0 : 32'd1);
      check($sformatf("stream%0d.o_en", k), W'(en), 32'd1);
      if (k > 0) begin
        check($sformatf("stream%0d.o_vld", k), W'(ovld), 32'd1);
        check($sformatf("stream%0d.o_z", k), z, exp_q.pop_front());
      end else begin
        check("stream0.o_vld", W'(ovld), 32'd0);
      end
    end
    drive(1'b0, 1'b0, '0, 1'b0);
    @(negedge clk);
    check("stream.drained.o_cnt", W'(cnt), 32'd0);
    check("stream.queue_empty", W'(exp_q.size()), 32'd0);

    // asynchronous reset mid-cycle with two entries buffered
    drive(1'b0, 1'b1, 32'hA1, 1'b0);
    drive(1'b0, 1'b1, 32'hA2, 1'b0);
    drive(1'b0, 1'b0, '0, 1'b0);
    @(negedge clk);
    check_all("prerst", 1'b1, 1'b1, 32'hA1, 2);
    #2;
    rst = 1'b1;
    #1;
    check_all("async_rst", 1'b1, 1'b0, 32'h0, 0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    drive(1'b0, 1'b1, 32'h77, 1'b0);
    @(negedge clk);
    check_all("post_rst_push", 1'b1, 1'b0, 32'h0, 0);
    drive(1'b0, 1'b0, '0, 1'b1);
    @(negedge clk);
    check_all("post_rst_visible", 1'b1, 1'b1, 32'h77, 1);
    drive(1'b0, 1'b0, '0, 1'b0);
    @(negedge clk);
    check_all("post_rst_empty", 1'b1, 1'b0, 32'h0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/lix_shr_sink.md
LIX_SHR_SINK -- requirements
Module: lix_shr_sink

Interface
REQ-001 Parameter W, default 32, data width of pipeline payload.
REQ-002 Parameter D, default 4, buffer depth in entries; SHALL be a power of two, 2..64.
REQ-003 clk_i  input  1  single clock, all state on rising edge.
REQ-004 rst_i  input  1  reset, asynchronous, active-high.
REQ-005 i_vld  input  1  valid from the last stage of the upstream enable-stalled pipeline.
REQ-006 i_x  input  W  data from the last stage of the upstream pipeline.
REQ-007 o_en  output  1  pipeline advance enable driven back to every upstream stage.
REQ-008 i_flush  input  1  synchronous buffer clear.
REQ-009 o_vld  output  1  downstream valid.
REQ-010 i_rdy  input  1  downstream ready.
REQ-011 o_z  output  W  downstream data.
REQ-012 o_cnt  output  $clog2(D)+1  current occupancy, 0..D.

Function
REQ-013 o_en SHALL equal (o_cnt != D) & !i_flush, decoded from registered state only; no combinational path from i_rdy or i_vld to o_en.
REQ-014 Push SHALL occur on an edge where o_en=1 and i_vld=1; i_x written at write pointer.
REQ-015 When o_en=1 and i_vld=0 the pipeline bubble SHALL be consumed with no write.
REQ-016 When o_en=0, i_vld and i_x SHALL be ignored (upstream holds its data).
REQ-017 Pop SHALL occur on an edge where o_vld=1 and i_rdy=1; read pointer advances.
REQ-018 o_vld SHALL equal (o_cnt != 0); o_z SHALL present the entry at read pointer (first-word-fall-through), and SHALL be all-zero when o_vld=0.
REQ-019 Latency: an item pushed at edge t SHALL be visible on o_vld/o_z in the cycle after edge t; no same-cycle bypass.
REQ-020 Simultaneous push and pop SHALL leave o_cnt unchanged and move both pointers.
REQ-021 Full (o_cnt=D) with pop: o_en stays 0 that cycle; o_en returns to 1 the cycle after the pop.
REQ-022 Read and write pointers SHALL wrap modulo D; data order SHALL be strict FIFO across wrap.
REQ-023 i_flush=1 SHALL have priority over push and pop: next state o_cnt=0, both pointers 0, in-flight pop discarded.
REQ-024 o_vld/o_z/o_cnt SHALL hold stable while o_vld=1 and i_rdy=0, except by push incrementing o_cnt.
REQ-025 Overflow SHALL be impossible by construction; push with o_cnt=D cannot occur.

Reset
REQ-026 rst_i=1 SHALL immediately force o_cnt=0, pointers 0, o_vld=0, o_z=0, o_en=1 (when i_flush=0).
REQ-027 Storage array contents SHALL not require reset; masking per REQ-018 guarantees deterministic o_z.
REQ-028 Reset assertion mid-transfer SHALL discard all buffered entries; first post-reset push lands at entry 0.

Structure
REQ-029 Shared package/header SHALL hold the depth limits (D_MIN=2, D_MAX=64) and the occupancy width function.
REQ-030 One sub-module lix_sink_mem (D x W register array, one write port, one async read port) SHALL hold storage; pointers, count and enable logic stay in lix_shr_sink.

Verification
REQ-031 Reset, then D=4, i_vld=1 with x=1,2,3,4,5, i_rdy=0 -> o_cnt reaches 4, o_en=0, value 5 held upstream, o_z=1.
REQ-032 From full, i_rdy=1 one cycle -> pop of 1, o_en=1 next cycle, 5 pushed, o_z sequence 2,3,4,5.
REQ-033 Continuous i_vld=1 and i_rdy=1 for 20 items 0..19 -> o_cnt oscillates 0/1, output order 0..19, pointers wrap 5 times, no loss.
REQ-034 Buffer holding 3 entries, i_flush=1 with i_vld=1, i_rdy=1 -> o_en=0 that cycle, next cycle o_cnt=0, o_vld=0, o_z=0.
REQ-035 Alternating i_vld bubbles (1,0,1,0) with i_rdy=1 -> only valid items stored, o_cnt never exceeds 1.
REQ-036 rst_i asserted asynchronously mid-cycle with o_cnt=2 -> o_vld=0 and o_cnt=0 before next edge; first item after release appears one cycle after its push.
